// File: rtl/dhcp_server.sv
// dhcp_server: minimal DHCP responder that parses BOOTREQUEST payloads and
// builds a 256-byte DHCPOFFER/DHCPACK for the UDP transmit path.
// Ports: clock/reset; rx_data/rx_enable/dhcp_rx_active receive stream;
// udp_tx_enable/udp_tx_active tx handshake; dhcp_tx_request, tx_data, length
// reply stream; lease_granted/granted_mac/dropped status; fixed destination.
module dhcp_server #(
  parameter logic [31:0] OFFER_IP      = 32'hC0A80164,
  parameter logic [31:0] SERVER_IP     = 32'hC0A80101,
  parameter logic [31:0] LEASE_SECONDS = 32'd86400
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_enable,
  input  logic        dhcp_rx_active,
  input  logic        udp_tx_enable,
  input  logic        udp_tx_active,
  output logic        dhcp_tx_request,
  output logic [7:0]  tx_data,
  output logic [15:0] length,
  output logic        lease_granted,
  output logic [47:0] granted_mac,
  output logic [7:0]  dropped,
  output logic [47:0] dhcp_destination_mac,
  output logic [31:0] dhcp_destination_ip,
  output logic [15:0] dhcp_destination_port
);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_BODY,
    RX_SKIP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_REQ,
    TX_SEND
  } tx_state_t;

  rx_state_t   rx_state, rx_next;
  tx_state_t   tx_state, tx_next;

  logic [8:0]  idx;
  logic [31:0] rx_xid;
  logic [47:0] rx_mac;
  logic [47:0] offer_mac;
  logic        offer_valid;
  logic        pending;

  logic [31:0] tx_xid;
  logic [47:0] tx_mac;
  logic [7:0]  tx_type;
  logic [8:0]  byte_no;

  logic        accept;
  logic        decide;
  logic        is_discover;
  logic [7:0]  reply_type;
  logic        magic_bad;
  logic        busy;

  assign dhcp_destination_mac  = 48'hFFFFFFFFFFFF;
  assign dhcp_destination_ip   = 32'hFFFFFFFF;
  assign dhcp_destination_port = 16'd68;

  assign accept = rx_enable & dhcp_rx_active;
  assign busy   = pending | (tx_state != TX_IDLE);

  // Fixed magic cookie and message-type option header at 236..241.
  always_comb begin
    magic_bad = 1'b0;
    case (idx)
      9'd236:  magic_bad = (rx_data != 8'h63);
      9'd237:  magic_bad = (rx_data != 8'h82);
      9'd238:  magic_bad = (rx_data != 8'h53);
      9'd239:  magic_bad = (rx_data != 8'h63);
      9'd240:  magic_bad = (rx_data != 8'h35);
      9'd241:  magic_bad = (rx_data != 8'h01);
      default: magic_bad = 1'b0;
    endcase
  end

  always_comb begin
    rx_next     = rx_state;
    decide      = 1'b0;
    is_discover = 1'b0;
    reply_type  = 8'h00;
    if (!dhcp_rx_active) begin
      rx_next = RX_IDLE;
    end else if (rx_enable) begin
      case (rx_state)
        RX_IDLE: begin
          rx_next = (rx_data == 8'h01) ? RX_BODY : RX_SKIP;
        end
        RX_BODY: begin
          if (magic_bad) begin
            rx_next = RX_SKIP;
          end else if (idx == 9'd242) begin
            // Decision made; the rest of the frame is ignored.
            rx_next = RX_SKIP;
            if (rx_data == 8'h01) begin
              decide      = 1'b1;
              is_discover = 1'b1;
              reply_type  = 8'h02;
            end else if (rx_data == 8'h03 && offer_valid &&
                         rx_mac == offer_mac) begin
              decide     = 1'b1;
              reply_type = 8'h05;
            end
          end
        end
        default: rx_next = RX_SKIP;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      idx      <= 9'd0;
      rx_xid   <= 32'd0;
      rx_mac   <= 48'd0;
    end else begin
      rx_state <= rx_next;
      if (!dhcp_rx_active) begin
        idx <= 9'd0;
      end else if (rx_enable) begin
        if (idx != 9'd511)
          idx <= idx + 9'd1;
        // Fields arrive in order, so shift them in MSB first.
        if (idx >= 9'd4 && idx <= 9'd7)
          rx_xid <= {rx_xid[23:0], rx_data};
        if (idx >= 9'd28 && idx <= 9'd33)
          rx_mac <= {rx_mac[39:0], rx_data};
      end
    end
  end

  function automatic logic [7:0] reply_byte(
    input logic [8:0]  n,
    input logic [31:0] xid,
    input logic [47:0] mac,
    input logic [7:0]  typ
  );
    logic [7:0] b;
    b = 8'h00;
    case (n)
      9'd0:   b = 8'h02;
      9'd1:   b = 8'h01;
      9'd2:   b = 8'h06;
      9'd4:   b = xid[31:24];
      9'd5:   b = xid[23:16];
      9'd6:   b = xid[15:8];
      9'd7:   b = xid[7:0];
      9'd16:  b = OFFER_IP[31:24];
      9'd17:  b = OFFER_IP[23:16];
      9'd18:  b = OFFER_IP[15:8];
      9'd19:  b = OFFER_IP[7:0];
      9'd20:  b = SERVER_IP[31:24];
      9'd21:  b = SERVER_IP[23:16];
      9'd22:  b = SERVER_IP[15:8];
      9'd23:  b = SERVER_IP[7:0];
      9'd28:  b = mac[47:40];
      9'd29:  b = mac[39:32];
      9'd30:  b = mac[31:24];
      9'd31:  b = mac[23:16];
      9'd32:  b = mac[15:8];
      9'd33:  b = mac[7:0];
      9'd236: b = 8'h63;
      9'd237: b = 8'h82;
      9'd238: b = 8'h53;
      9'd239: b = 8'h63;
      9'd240: b = 8'h35;
      9'd241: b = 8'h01;
      9'd242: b = typ;
      9'd243: b = 8'h36;
      9'd244: b = 8'h04;
      9'd245: b = SERVER_IP[31:24];
      9'd246: b = SERVER_IP[23:16];
      9'd247: b = SERVER_IP[15:8];
      9'd248: b = SERVER_IP[7:0];
      9'd249: b = 8'h33;
      9'd250: b = 8'h04;
      9'd251: b = LEASE_SECONDS[31:24];
      9'd252: b = LEASE_SECONDS[23:16];
      9'd253: b = LEASE_SECONDS[15:8];
      9'd254: b = LEASE_SECONDS[7:0];
      9'd255: b = 8'hFF;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (pending) tx_next = TX_REQ;
      TX_REQ:  if (udp_tx_enable) tx_next = TX_SEND;
      TX_SEND: begin
        if (udp_tx_active && byte_no == 9'd256)
          tx_next = TX_IDLE;
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state        <= TX_IDLE;
      pending         <= 1'b0;
      offer_valid     <= 1'b0;
      offer_mac       <= 48'd0;
      tx_xid          <= 32'd0;
      tx_mac          <= 48'd0;
      tx_type         <= 8'd0;
      byte_no         <= 9'd0;
      dhcp_tx_request <= 1'b0;
      tx_data         <= 8'd0;
      length          <= 16'd0;
      lease_granted   <= 1'b0;
      granted_mac     <= 48'd0;
      dropped         <= 8'd0;
    end else begin
      tx_state <= tx_next;
      case (tx_state)
        TX_IDLE: begin
          byte_no <= 9'd1;
        end
        TX_REQ: begin
          dhcp_tx_request <= 1'b1;
          length          <= 16'd256;
          if (udp_tx_enable) begin
            tx_data <= 8'h02;
            pending <= 1'b0;
          end
        end
        TX_SEND: begin
          if (udp_tx_active) begin
            if (byte_no == 9'd256) begin
              dhcp_tx_request <= 1'b0;
              length          <= 16'd0;
              if (tx_type == 8'h05) begin
                lease_granted <= 1'b1;
                granted_mac   <= tx_mac;
              end
            end else begin
              tx_data <= reply_byte(byte_no, tx_xid, tx_mac, tx_type);
              byte_no <= byte_no + 9'd1;
            end
          end
        end
        default: ;
      endcase
      // Busy is only false in TX_IDLE, so this never races the clear above.
      if (decide) begin
        if (busy) begin
          if (dropped != 8'hFF)
            dropped <= dropped + 8'd1;
        end else begin
          tx_xid  <= rx_xid;
          tx_mac  <= rx_mac;
          tx_type <= reply_type;
          pending <= 1'b1;
        end
        if (is_discover) begin
          offer_mac   <= rx_mac;
          offer_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dhcp_server.sv
// tb_dhcp_server: directed self-checking bench for dhcp_server.
// Drives request frames, collects replies and compares against a byte map.
module tb_dhcp_server;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_enable = 1'b0;
  logic        dhcp_rx_active = 1'b0;
  logic        udp_tx_enable = 1'b0;
  logic        udp_tx_active = 1'b0;
  logic        dhcp_tx_request;
  logic [7:0]  tx_data;
  logic [15:0] length;
  logic        lease_granted;
  logic [47:0] granted_mac;
  logic [7:0]  dropped;
  logic [47:0] dhcp_destination_mac;
  logic [31:0] dhcp_destination_ip;
  logic [15:0] dhcp_destination_port;

  int nvec = 0;
  int nfail = 0;
  logic [7:0] got [256];

  localparam logic [47:0] MAC_A = 48'h001CC0A213DD;
  localparam logic [47:0] MAC_B = 48'h001CC0A213DE;

  always #5 clock = ~clock;

  dhcp_server dut (
    .clock(clock),
    .reset(reset),
    .rx_data(rx_data),
    .rx_enable(rx_enable),
    .dhcp_rx_active(dhcp_rx_active),
    .udp_tx_enable(udp_tx_enable),
    .udp_tx_active(udp_tx_active),
    .dhcp_tx_request(dhcp_tx_request),
    .tx_data(tx_data),
    .length(length),
    .lease_granted(lease_granted),
    .granted_mac(granted_mac),
    .dropped(dropped),
    .dhcp_destination_mac(dhcp_destination_mac),
    .dhcp_destination_ip(dhcp_destination_ip),
    .dhcp_destination_port(dhcp_destination_port)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] frame_byte(
    input int i, input logic [31:0] xid, input logic [47:0] mac,
    input logic [7:0] b0, input logic [7:0] b236, input logic [7:0] b242);
    logic [31:0] iv;
    iv = i;
    if (i == 0) return b0;
    if (i >= 4 && i <= 7) return xid[8*(7-i) +: 8];
    if (i >= 28 && i <= 33) return mac[8*(33-i) +: 8];
    if (i == 236) return b236;
    if (i == 237) return 8'h82;
    if (i == 238) return 8'h53;
    if (i == 239) return 8'h63;
    if (i == 240) return 8'h35;
    if (i == 241) return 8'h01;
    if (i == 242) return b242;
    return iv[7:0];
  endfunction

  function automatic logic [7:0] exp_byte(
    input int n, input logic [31:0] xid, input logic [47:0] mac,
    input logic [7:0] typ);
    logic [31:0] oip;
    logic [31:0] sip;
    logic [31:0] lease;
    oip = 32'hC0A80164;
    sip = 32'hC0A80101;
    lease = 32'd86400;
    if (n == 0) return 8'h02;
    if (n == 1) return 8'h01;
    if (n == 2) return 8'h06;
    if (n >= 4 && n <= 7) return xid[8*(7-n) +: 8];
    if (n >= 16 && n <= 19) return oip[8*(19-n) +: 8];
    if (n >= 20 && n <= 23) return sip[8*(23-n) +: 8];
    if (n >= 28 && n <= 33) return mac[8*(33-n) +: 8];
    if (n == 236) return 8'h63;
    if (n == 237) return 8'h82;
    if (n == 238) return 8'h53;
    if (n == 239) return 8'h63;
    if (n == 240) return 8'h35;
    if (n == 241) return 8'h01;
    if (n == 242) return typ;
    if (n == 243) return 8'h36;
    if (n == 244) return 8'h04;
    if (n >= 245 && n <= 248) return sip[8*(248-n) +: 8];
    if (n == 249) return 8'h33;
    if (n == 250) return 8'h04;
    if (n >= 251 && n <= 254) return lease[8*(254-n) +: 8];
    if (n == 255) return 8'hFF;
    return 8'h00;
  endfunction

  task automatic send_frame(input logic [31:0] xid, input logic [47:0] mac,
                            input logic [7:0] b0, input logic [7:0] b236,
                            input logic [7:0] b242, input int last);
    for (int i = 0; i <= last; i++) begin
      @(negedge clock);
      dhcp_rx_active = 1'b1;
      rx_enable = 1'b1;
      rx_data = frame_byte(i, xid, mac, b0, b236, b242);
    end
    @(negedge clock);
    rx_enable = 1'b0;
    dhcp_rx_active = 1'b0;
    rx_data = 8'd0;
  endtask

  task automatic get_reply(input int stop_at, input bit toggle);
    int w;
    w = 0;
    while (!dhcp_tx_request && w < 30) begin
      @(negedge clock);
      w++;
    end
    if (!dhcp_tx_request) begin
      chk("req_seen", 64'(dhcp_tx_request), 64'd1);
      return;
    end
    chk("length", 64'(length), 64'd256);
    udp_tx_enable = 1'b1;
    @(negedge clock);
    udp_tx_enable = 1'b0;
    got[0] = tx_data;
    for (int n = 1; n <= stop_at && n < 256; n++) begin
      if (toggle) begin
        udp_tx_active = 1'b0;
        @(negedge clock);
      end
      udp_tx_active = 1'b1;
      @(negedge clock);
      got[n] = tx_data;
    end
    udp_tx_active = 1'b0;
    if (stop_at < 255) return;
    chk("req_hold", 64'(dhcp_tx_request), 64'd1);
    udp_tx_active = 1'b1;
    @(negedge clock);
    udp_tx_active = 1'b0;
    chk("req_fall", 64'(dhcp_tx_request), 64'd0);
  endtask

  task automatic check_reply(input string tag, input logic [31:0] xid,
                             input logic [47:0] mac, input logic [7:0] typ);
    for (int n = 0; n < 256; n++)
      chk($sformatf("%s_b%0d", tag, n), 64'(got[n]),
          64'(exp_byte(n, xid, mac, typ)));
  endtask

  task automatic expect_silent(input string tag);
    bit seen;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (dhcp_tx_request) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    chk("rst_req", 64'(dhcp_tx_request), 64'd0);
    chk("rst_data", 64'(tx_data), 64'd0);
    chk("rst_len", 64'(length), 64'd0);
    chk("rst_lease", 64'(lease_granted), 64'd0);
    chk("rst_gmac", 64'(granted_mac), 64'd0);
    chk("rst_drop", 64'(dropped), 64'd0);
    chk("dst_mac", 64'(dhcp_destination_mac), 64'hFFFFFFFFFFFF);
    chk("dst_ip", 64'(dhcp_destination_ip), 64'hFFFFFFFF);
    chk("dst_port", 64'(dhcp_destination_port), 64'd68);

    // REQUEST with no prior offer
    send_frame(32'h01020304, MAC_A, 8'h01, 8'h63, 8'h03, 243);
    expect_silent("req_no_offer");
    chk("drop_no_offer", 64'(dropped), 64'd0);

    // DISCOVER -> OFFER
    send_frame(32'h12345678, MAC_A, 8'h01, 8'h63, 8'h01, 243);
    get_reply(255, 1'b0);
    check_reply("offer", 32'h12345678, MAC_A, 8'h02);
    chk("lease_after_offer", 64'(lease_granted), 64'd0);

    // REQUEST from another MAC
    send_frame(32'h0000BEEF, MAC_B, 8'h01, 8'h63, 8'h03, 243);
    expect_silent("req_wrong_mac");
    chk("drop_wrong_mac", 64'(dropped), 64'd0);

    // REQUEST from offered MAC -> ACK
    send_frame(32'h9ABCDEF0, MAC_A, 8'h01, 8'h63, 8'h03, 243);
    get_reply(255, 1'b0);
    check_reply("ack", 32'h9ABCDEF0, MAC_A, 8'h05);
    chk("lease", 64'(lease_granted), 64'd1);
    chk("gmac", 64'(granted_mac), 64'(MAC_A));

    // Malformed and truncated frames
    send_frame(32'h11111111, MAC_A, 8'h01, 8'h00, 8'h01, 243);
    expect_silent("bad_cookie");
    send_frame(32'h22222222, MAC_A, 8'h02, 8'h63, 8'h01, 243);
    expect_silent("bad_op");
    send_frame(32'h33333333, MAC_A, 8'h01, 8'h63, 8'h01, 200);
    expect_silent("truncated");

    // Good DISCOVER afterwards, with gapped udp_tx_active
    send_frame(32'hA5A55A5A, MAC_B, 8'h01, 8'h63, 8'h01, 243);
    get_reply(255, 1'b1);
    check_reply("toggle", 32'hA5A55A5A, MAC_B, 8'h02);

    // Second DISCOVER lands mid-reply and is dropped
    send_frame(32'hCAFEF00D, MAC_A, 8'h01, 8'h63, 8'h01, 243);
    fork
      send_frame(32'h0BADBEEF, MAC_B, 8'h01, 8'h63, 8'h01, 243);
      begin
        repeat (190) @(negedge clock);
        get_reply(255, 1'b0);
      end
    join
    check_reply("busy", 32'hCAFEF00D, MAC_A, 8'h02);
    chk("dropped", 64'(dropped), 64'd1);
    expect_silent("no_late_reply");

    // Reset mid-transmit
    send_frame(32'h11223344, MAC_A, 8'h01, 8'h63, 8'h01, 243);
    get_reply(100, 1'b0);
    chk("pre_rst_req", 64'(dhcp_tx_request), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_req", 64'(dhcp_tx_request), 64'd0);
    chk("mid_rst_data", 64'(tx_data), 64'd0);
    chk("mid_rst_len", 64'(length), 64'd0);
    chk("mid_rst_lease", 64'(lease_granted), 64'd0);
    chk("mid_rst_gmac", 64'(granted_mac), 64'd0);
    chk("mid_rst_drop", 64'(dropped), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    send_frame(32'h55667788, MAC_A, 8'h01, 8'h63, 8'h01, 243);
    get_reply(255, 1'b0);
    check_reply("post_rst", 32'h55667788, MAC_A, 8'h02);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/dhcp_server.md
# dhcp_server

Minimal DHCP responder answering the Hermes-Lite DHCP client on a direct PC link or in loopback test builds. It parses BOOTREQUEST payloads (UDP port 67) from the UDP receive byte stream and builds a 256-byte DHCPOFFER or DHCPACK for the UDP transmit path. Field offsets and the request/grant/active transmit handshake match the client block, so the two interoperate directly. It runs on a single clock: the receive and transmit sides share it.

## Interface
- OFFER_IP, 32'hC0A80164, address offered in yiaddr (192.168.1.100)
- SERVER_IP, 32'hC0A80101, server identifier and siaddr (192.168.1.1)
- LEASE_SECONDS, 32'd86400, value sent in option 0x33
- clock  in  1  single clock for rx and tx
- reset  in  1  asynchronous, active-high
- rx_data  in  8  UDP payload byte
- rx_enable  in  1  rx_data valid this cycle
- dhcp_rx_active  in  1  high for the entire payload of a port-67 datagram
- udp_tx_enable  in  1  grant from the UDP transmitter
- udp_tx_active  in  1  transmitter consumes one byte this cycle
- dhcp_tx_request  out  1  reply pending or being sent
- tx_data  out  8  reply byte
- length  out  16  reply payload length, always 256 when requesting
- lease_granted  out  1  sticky; set when an ACK finishes sending
- granted_mac  out  48  chaddr of the last ACKed client
- dropped  out  8  saturating count of valid requests discarded while busy
- dhcp_destination_mac  out  48  constant 48'hFFFFFFFFFFFF
- dhcp_destination_ip  out  32  constant 32'hFFFFFFFF
- dhcp_destination_port  out  16  constant 16'd68

## Operation
- Reset values:
  - all outputs 0 except the constants
  - offer_valid=0, pending=0
  - rx state RX_IDLE, tx state TX_IDLE
- RX byte index counts accepted bytes (rx_enable & dhcp_rx_active) from 0. A deassertion of dhcp_rx_active returns the parser to RX_IDLE with index 0.
- Per-byte checks:
  - byte 0 must be 0x01, otherwise RX_SKIP until dhcp_rx_active falls
  - bytes 4-7 are captured into rx_xid
  - bytes 28-33 are captured into rx_mac
  - bytes 236-239 must be 63 82 53 63, otherwise skip
  - bytes 240-241 must be 35 01, otherwise skip
- Byte 242 decides the reply:
  - 0x01 (DISCOVER): reply type 0x02
  - 0x03 (REQUEST) with offer_valid and rx_mac==offer_mac: reply type 0x05
  - any other value: skip
  - Bytes after 242 are ignored.
- Accepting a reply at byte 242:
  - if busy (pending, or tx state not TX_IDLE): dropped increments, saturating at 255; tx registers unchanged
  - otherwise: tx_xid/tx_mac/tx_type are loaded from the rx registers, and pending<=1
  - on a DISCOVER, offer_mac<=rx_mac and offer_valid<=1
- TX states:
  - TX_IDLE: byte_no<=1. If pending, go to TX_REQ.
  - TX_REQ: dhcp_tx_request<=1, length<=256. On udp_tx_enable: tx_data<=8'h02 (byte 0), pending<=0, go to TX_SEND.
  - TX_SEND: each cycle with udp_tx_active, tx_data<=byte[byte_no] and byte_no increments. Once byte_no==256, dhcp_tx_request<=0 and the state returns to TX_IDLE.
  - Leaving TX_SEND with tx_type 0x05: lease_granted<=1 and granted_mac<=tx_mac.
- Reply byte map (all unlisted bytes are 0):
  - 0 = 02, 1 = 01, 2 = 06
  - 4-7 = xid
  - 16-19 = OFFER_IP, 20-23 = SERVER_IP
  - 28-33 = chaddr
  - 236-239 = 63 82 53 63
  - 240 = 35, 241 = 01, 242 = type
  - 243 = 36, 244 = 04, 245-248 = SERVER_IP
  - 249 = 33, 250 = 04, 251-254 = LEASE_SECONDS
  - 255 = FF
- Byte offsets are 9-bit; there is no wrap-around. RX index saturates at 511.

## Timing
- Pending is set on the edge that samples byte 242. TX_REQ is entered on the next edge, so dhcp_tx_request is high 2 edges after byte 242.
- Byte 0 is presented the cycle after udp_tx_enable, before udp_tx_active rises.
- Byte n appears one edge after the nth udp_tx_active cycle. Gaps in udp_tx_active hold tx_data.
- dhcp_tx_request falls on the edge after byte 255 is loaded plus one further udp_tx_active cycle (byte_no reaching 256).
- An rx decision in the same cycle the FSM returns to TX_IDLE counts as busy and is dropped.
- Reset mid-operation clears everything asynchronously; dhcp_tx_request drops without waiting for clock.

## Test plan
- DISCOVER, xid 0x12345678, chaddr 00:1C:C0:A2:13:DD -> request with length 256; tx bytes 0=02, 4-7=12 34 56 78, 16-19=C0 A8 01 64, 28-33 = the chaddr, 242=02, 255=FF; request falls after 256 bytes.
- Same client then sends REQUEST (242=03) -> reply with 242=05, 251-254=00 01 51 80; lease_granted=1, granted_mac=001CC0A213DD.
- REQUEST from chaddr 00:1C:C0:A2:13:DE, or with no prior offer -> no dhcp_tx_request, dropped stays 0.
- DISCOVER with byte 236=00, or byte 0=02 -> no response. Truncated frame (dhcp_rx_active falls at byte 200) -> no response, and the next good DISCOVER is answered.
- Second DISCOVER completes while the first reply is at byte 50 -> dropped=1; first reply's xid/chaddr bytes unchanged.
- udp_tx_active toggled 1/0 every cycle -> identical byte sequence. Reset at byte 100 -> outputs 0 immediately; next DISCOVER answered normally.
